// File: rtl/ps2_keymap_pkg.sv
// Shared types and constants for the PS/2 Set-2 to NES-button decoder.
// Extended (E0) keymap support is gated by the PS2_DECODE_E0_EN macro.
package ps2_keymap_pkg;

  localparam int unsigned BTN_W  = 8;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned CODE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_e;

  // Prefix and keyboard self-test bytes
  localparam logic [CODE_W-1:0] PS2_BRK     = 8'hF0;
  localparam logic [CODE_W-1:0] PS2_EXT     = 8'hE0;
  localparam logic [CODE_W-1:0] PS2_BAT     = 8'hAA;
  localparam logic [CODE_W-1:0] PS2_BAT_ERR = 8'hFC;

  // Main keymap scancodes
  localparam logic [CODE_W-1:0] SC_K      = 8'h42;
  localparam logic [CODE_W-1:0] SC_J      = 8'h3B;
  localparam logic [CODE_W-1:0] SC_RSHIFT = 8'h59;
  localparam logic [CODE_W-1:0] SC_ENTER  = 8'h5A;
  localparam logic [CODE_W-1:0] SC_W      = 8'h1D;
  localparam logic [CODE_W-1:0] SC_S      = 8'h1B;
  localparam logic [CODE_W-1:0] SC_A      = 8'h1C;
  localparam logic [CODE_W-1:0] SC_D      = 8'h23;

  // Extended keymap scancodes (arrow keys, follow E0)
  localparam logic [CODE_W-1:0] SC_EXT_UP    = 8'h75;
  localparam logic [CODE_W-1:0] SC_EXT_DN    = 8'h72;
  localparam logic [CODE_W-1:0] SC_EXT_LEFT  = 8'h6B;
  localparam logic [CODE_W-1:0] SC_EXT_RIGHT = 8'h74;

  // Button bit positions, NES controller order
  localparam logic [IDX_W-1:0] BTN_A    = 3'd0;
  localparam logic [IDX_W-1:0] BTN_B    = 3'd1;
  localparam logic [IDX_W-1:0] BTN_SEL  = 3'd2;
  localparam logic [IDX_W-1:0] BTN_STRT = 3'd3;
  localparam logic [IDX_W-1:0] BTN_UP   = 3'd4;
  localparam logic [IDX_W-1:0] BTN_DN   = 3'd5;
  localparam logic [IDX_W-1:0] BTN_L    = 3'd6;
  localparam logic [IDX_W-1:0] BTN_R    = 3'd7;

endpackage

// File: rtl/ps2_scancode_lookup.sv
// Combinational scancode-to-button lookup for the main and E0 keymaps.
module ps2_scancode_lookup
  import ps2_keymap_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  input  logic              ext_i,
  output logic              hit_c_o,
  output logic [IDX_W-1:0]  idx_c_o
);

  always_comb begin
    hit_c_o = 1'b0;
    idx_c_o = '0;
    if (ext_i) begin
      unique case (code_i)
        SC_EXT_UP:    begin hit_c_o = 1'b1; idx_c_o = BTN_UP; end
        SC_EXT_DN:    begin hit_c_o = 1'b1; idx_c_o = BTN_DN; end
        SC_EXT_LEFT:  begin hit_c_o = 1'b1; idx_c_o = BTN_L;  end
        SC_EXT_RIGHT: begin hit_c_o = 1'b1; idx_c_o = BTN_R;  end
        default:      ;
      endcase
    end else begin
      unique case (code_i)
        SC_K:      begin hit_c_o = 1'b1; idx_c_o = BTN_A;    end
        SC_J:      begin hit_c_o = 1'b1; idx_c_o = BTN_B;    end
        SC_RSHIFT: begin hit_c_o = 1'b1; idx_c_o = BTN_SEL;  end
        SC_ENTER:  begin hit_c_o = 1'b1; idx_c_o = BTN_STRT; end
        SC_W:      begin hit_c_o = 1'b1; idx_c_o = BTN_UP;   end
        SC_S:      begin hit_c_o = 1'b1; idx_c_o = BTN_DN;   end
        SC_A:      begin hit_c_o = 1'b1; idx_c_o = BTN_L;    end
        SC_D:      begin hit_c_o = 1'b1; idx_c_o = BTN_R;    end
        default:   ;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 Set-2 make/break decoder producing a held NES-order button vector.
// Define PS2_DECODE_E0_EN to compile in the E0 (arrow key) keymap.
module ps2_key_decoder
  import ps2_keymap_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CODE_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              rx_err,
  output logic [BTN_W-1:0]  buttons,
  output logic              btn_changed
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  ps2_state_e       state_q, state_d;
  logic [BTN_W-1:0] main_q, main_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BTN_W-1:0] btn_d;
  logic             lk_ext;
  logic             lk_hit;
  logic [IDX_W-1:0] lk_idx;
`ifdef PS2_DECODE_E0_EN
  logic [BTN_W-1:0] ext_q, ext_d;
`endif

  assign lk_ext = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);

  ps2_scancode_lookup u_lookup (
    .code_i  (rx_data),
    .ext_i   (lk_ext),
    .hit_c_o (lk_hit),
    .idx_c_o (lk_idx)
  );

  // Next-state: error beats a byte, a byte beats the prefix timeout
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    cnt_d   = cnt_q;
`ifdef PS2_DECODE_E0_EN
    ext_d   = ext_q;
`endif
    if (rx_err) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (rx_valid) begin
      cnt_d = '0;
      unique case (state_q)
        ST_IDLE: begin
          if (rx_data == PS2_BRK) begin
            state_d = ST_BRK;
          end else if (rx_data == PS2_EXT) begin
            state_d = ST_EXT;
          end else if ((rx_data == PS2_BAT) || (rx_data == PS2_BAT_ERR)) begin
            main_d = '0;
`ifdef PS2_DECODE_E0_EN
            ext_d  = '0;
`endif
          end else if (lk_hit) begin
            main_d[lk_idx] = 1'b1;
          end
        end
        ST_BRK: begin
          if (lk_hit) main_d[lk_idx] = 1'b0;
          state_d = ST_IDLE;
        end
        ST_EXT: begin
          if (rx_data == PS2_BRK) begin
            state_d = ST_EXT_BRK;
          end else begin
`ifdef PS2_DECODE_E0_EN
            if (lk_hit) ext_d[lk_idx] = 1'b1;
`endif
            state_d = ST_IDLE;
          end
        end
        ST_EXT_BRK: begin
`ifdef PS2_DECODE_E0_EN
          if (lk_hit) ext_d[lk_idx] = 1'b0;
`endif
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      if (cnt_q == CNT_LAST) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

`ifdef PS2_DECODE_E0_EN
  assign btn_d = main_d | ext_d;
`else
  assign btn_d = main_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      main_q      <= '0;
      cnt_q       <= '0;
      buttons     <= '0;
      btn_changed <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      cnt_q       <= cnt_d;
      buttons     <= btn_d;
      btn_changed <= (btn_d != buttons);
    end
  end

`ifdef PS2_DECODE_E0_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ext_q <= '0;
    else       ext_q <= ext_d;
  end
`endif

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed self-checking bench for ps2_key_decoder (short prefix timeout).
module tb_ps2_key_decoder;

  localparam int unsigned TO = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic [7:0] buttons;
  logic       btn_changed;

  int n_chk = 0;
  int n_err = 0;

  ps2_key_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_err      (rx_err),
    .buttons     (buttons),
    .btn_changed (btn_changed)
  );

  always #5 clk = ~clk;

  // Called at a negedge; presents one byte for one cycle and returns at the next negedge
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; rx_err = 1'b0;
    idle(2);
    n_chk++; if (buttons !== 8'h00) begin n_err++; $display("FAIL reset_buttons got %h exp %h", buttons, 8'h00); end
    n_chk++; if (btn_changed !== 1'b0) begin n_err++; $display("FAIL reset_changed got %b exp %b", btn_changed, 1'b0); end
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_make_break();
    send(8'h1D);
    n_chk++; if (buttons !== 8'h10) begin n_err++; $display("FAIL mb_make got %h exp %h", buttons, 8'h10); end
    n_chk++; if (btn_changed !== 1'b1) begin n_err++; $display("FAIL mb_make_pulse got %b exp %b", btn_changed, 1'b1); end
    idle(1);
    n_chk++; if (btn_changed !== 1'b0) begin n_err++; $display("FAIL mb_pulse_width got %b exp %b", btn_changed, 1'b0); end
    send(8'hF0);
    n_chk++; if (buttons !== 8'h10) begin n_err++; $display("FAIL mb_prefix_hold got %h exp %h", buttons, 8'h10); end
    send(8'h1D);
    n_chk++; if (buttons !== 8'h00) begin n_err++; $display("FAIL mb_break got %h exp %h", buttons, 8'h00); end
    n_chk++; if (btn_changed !== 1'b1) begin n_err++; $display("FAIL mb_break_pulse got %b exp %b", btn_changed, 1'b1); end
    idle(2);
  endtask

  task automatic test_back_to_back();
    rx_valid = 1'b1; rx_data = 8'h42;
    @(negedge clk);
    n_chk++; if (buttons !== 8'h01) begin n_err++; $display("FAIL b2b_k got %h exp %h", buttons, 8'h01); end
    n_chk++; if (btn_changed !== 1'b1) begin n_err++; $display("FAIL b2b_k_pulse got %b exp %b", btn_changed, 1'b1); end
    rx_data = 8'h5A;
    @(negedge clk);
    n_chk++; if (buttons !== 8'h09) begin n_err++; $display("FAIL b2b_enter got %h exp %h", buttons, 8'h09); end
    n_chk++; if (btn_changed !== 1'b1) begin n_err++; $display("FAIL b2b_enter_pulse got %b exp %b", btn_changed, 1'b1); end
    rx_data = 8'h42;
    @(negedge clk);
    n_chk++; if (buttons !== 8'h09) begin n_err++; $display("FAIL b2b_repeat got %h exp %h", buttons, 8'h09); end
    n_chk++; if (btn_changed !== 1'b0) begin n_err++; $display("FAIL b2b_repeat_pulse got %b exp %b", btn_changed, 1'b0); end
    rx_data = 8'hF0; @(negedge clk);
    rx_data = 8'h42; @(negedge clk);
    rx_data = 8'hF0; @(negedge clk);
    rx_data = 8'h5A; @(negedge clk);
    rx_valid = 1'b0; rx_data = 8'h00;
    n_chk++; if (buttons !== 8'h00) begin n_err++; $display("FAIL b2b_release got %h exp %h", buttons, 8'h00); end
    idle(2);
  endtask

  task automatic test_extended();
`ifdef PS2_DECODE_E0_EN
    send(8'h1D);
    send(8'hE0); send(8'h75);
    n_chk++; if (buttons !== 8'h10) begin n_err++; $display("FAIL ext_up_overlap got %h exp %h", buttons, 8'h10); end
    n_chk++; if (btn_changed !== 1'b0) begin n_err++; $display("FAIL ext_up_overlap_pulse got %b exp %b", btn_changed, 1'b0); end
    send(8'hF0); send(8'h1D);
    n_chk++; if (buttons !== 8'h10) begin n_err++; $display("FAIL ext_main_release got %h exp %h", buttons, 8'h10); end
    send(8'hE0); send(8'hF0); send(8'h75);
    n_chk++; if (buttons !== 8'h00) begin n_err++; $display("FAIL ext_break got %h exp %h", buttons, 8'h00); end
    n_chk++; if (btn_changed !== 1'b1) begin n_err++; $display("FAIL ext_break_pulse got %b exp %b", btn_changed, 1'b1); end
    send(8'hE0); send(8'h74);
    n_chk++; if (buttons !== 8'h80) begin n_err++; $display("FAIL ext_right got %h exp %h", buttons, 8'h80); end
    send(8'hE0); send(8'hF0); send(8'h74);
`else
    send(8'hE0); send(8'h75);
    n_chk++; if (buttons !== 8'h00) begin n_err++; $display("FAIL ext_disabled got %h exp %h", buttons, 8'h00); end
    n_chk++; if (btn_changed !== 1'b0) begin n_err++; $display("FAIL ext_disabled_pulse got %b exp %b", btn_changed, 1'b0); end
`endif
    send(8'hE0); send(8'h5A);
    n_chk++; if (buttons !== 8'h00) begin n_err++; $display("FAIL ext_5a_not_start got %h exp %h", buttons, 8'h00); end
    send(8'h1B);
    n_chk++; if (buttons !== 8'h20) begin n_err++; $display("FAIL ext_then_main got %h exp %h", buttons, 8'h20); end
    send(8'hF0); send(8'h1B);
    idle(2);
  endtask

  task automatic test_timeout_and_error();
    send(8'hF0);
    idle(TO);
    send(8'h1C);
    n_chk++; if (buttons !== 8'h40) begin n_err++; $display("FAIL to_expired_make got %h exp %h", buttons, 8'h40); end
    n_chk++; if (btn_changed !== 1'b1) begin n_err++; $display("FAIL to_expired_pulse got %b exp %b", btn_changed, 1'b1); end
    send(8'hF0);
    idle(TO - 1);
    send(8'h1C);
    n_chk++; if (buttons !== 8'h00) begin n_err++; $display("FAIL to_edge_break got %h exp %h", buttons, 8'h00); end
    send(8'hF0);
    rx_err = 1'b1; rx_valid = 1'b1; rx_data = 8'h23;
    @(negedge clk);
    rx_err = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    n_chk++; if (buttons !== 8'h00) begin n_err++; $display("FAIL err_discard got %h exp %h", buttons, 8'h00); end
    n_chk++; if (btn_changed !== 1'b0) begin n_err++; $display("FAIL err_discard_pulse got %b exp %b", btn_changed, 1'b0); end
    send(8'h23);
    n_chk++; if (buttons !== 8'h80) begin n_err++; $display("FAIL err_then_make got %h exp %h", buttons, 8'h80); end
    rx_err = 1'b1; @(negedge clk); rx_err = 1'b0;
    n_chk++; if (buttons !== 8'h80) begin n_err++; $display("FAIL err_keeps_held got %h exp %h", buttons, 8'h80); end
    send(8'hF0); send(8'h23);
    n_chk++; if (buttons !== 8'h00) begin n_err++; $display("FAIL err_release got %h exp %h", buttons, 8'h00); end
    idle(2);
  endtask

  task automatic test_bat();
    send(8'h1D); send(8'h1B);
    n_chk++; if (buttons !== 8'h30) begin n_err++; $display("FAIL bat_hold got %h exp %h", buttons, 8'h30); end
    send(8'hAA);
    n_chk++; if (buttons !== 8'h00) begin n_err++; $display("FAIL bat_clear got %h exp %h", buttons, 8'h00); end
    n_chk++; if (btn_changed !== 1'b1) begin n_err++; $display("FAIL bat_clear_pulse got %b exp %b", btn_changed, 1'b1); end
    send(8'h3B); send(8'h59);
    n_chk++; if (buttons !== 8'h06) begin n_err++; $display("FAIL bat_b_sel got %h exp %h", buttons, 8'h06); end
    send(8'hFC);
    n_chk++; if (buttons !== 8'h00) begin n_err++; $display("FAIL bat_err_clear got %h exp %h", buttons, 8'h00); end
    idle(2);
  endtask

  task automatic test_reset_mid();
    send(8'h1D);
    send(8'hF0);
    pulse_reset();
    n_chk++; if (buttons !== 8'h00) begin n_err++; $display("FAIL rst_mid_clear got %h exp %h", buttons, 8'h00); end
    send(8'h1D);
    n_chk++; if (buttons !== 8'h10) begin n_err++; $display("FAIL rst_mid_make got %h exp %h", buttons, 8'h10); end
    n_chk++; if (btn_changed !== 1'b1) begin n_err++; $display("FAIL rst_mid_pulse got %b exp %b", btn_changed, 1'b1); end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_back_to_back();
    test_extended();
    test_timeout_and_error();
    test_bat();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
